// File: rtl/bus_source_arbiter.sv
// Registered bus-source arbiter: fixed-priority or round-robin grant with conflict tracking.
// Optional BUS_ARB_CONFLICT_CAPTURE_EN latches the first conflicting req pattern.
module bus_source_arbiter #(
  parameter int N_SRC = 24,
  parameter int SEL_W = 5,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [N_SRC-1:0] req,
  input  logic             lock,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic [N_SRC-1:0] grant,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt
`ifdef BUS_ARB_CONFLICT_CAPTURE_EN
  ,
  output logic [N_SRC-1:0] conflict_mask
`endif
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic             conflict_q, conflict_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
`ifdef BUS_ARB_CONFLICT_CAPTURE_EN
  logic [N_SRC-1:0] mask_q, mask_d;
`endif

  logic [N_SRC-1:0] req_m1;
  logic [N_SRC-1:0] rot;
  logic             multi;
  logic             hold_c;
  logic             arb_c;
  logic             found;
  int               off;
  int               win_k;
  int               win_n;
  logic [SEL_W-1:0] win_sel;
  logic [SEL_W-1:0] win_ptr;
  logic [N_SRC-1:0] win_oh;

  // Two or more bits set iff clearing the lowest set bit leaves something.
  assign req_m1 = req - N_SRC'(1);
  assign multi  = |(req & req_m1);
  assign hold_c = (state_q == S_GRANT) && lock && |(req & grant_q);
  assign arb_c  = (|req) && !hold_c;

  // Rotate req so the search always starts at bit 0, then map back.
  always_comb begin
    rot   = req;
    found = 1'b0;
    off   = 0;
    win_k = 0;
    win_n = 0;
    if (MODE == 1) begin
      rot = N_SRC'({req, req} >> ptr_q);
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = i;
      end
    end
    win_k = off;
    if (MODE == 1) begin
      win_k = int'(ptr_q) + off;
    end
    if (win_k >= N_SRC) begin
      win_k = win_k - N_SRC;
    end
    win_n = win_k + 1;
    if (win_n >= N_SRC) begin
      win_n = 0;
    end
    win_sel = SEL_W'(win_k);
    win_ptr = SEL_W'(win_n);
    win_oh  = N_SRC'(1) << win_k;
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    valid_d    = valid_q;
    grant_d    = grant_q;
    conflict_d = conflict_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
`ifdef BUS_ARB_CONFLICT_CAPTURE_EN
    mask_d     = mask_q;
`endif
    if (en) begin
      conflict_d = multi;
      if (multi && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
`ifdef BUS_ARB_CONFLICT_CAPTURE_EN
      if (multi && (mask_q == '0)) begin
        mask_d = req;
      end
`endif
      unique case (1'b1)
        hold_c: begin
          state_d = S_GRANT;
        end
        arb_c: begin
          state_d = S_GRANT;
          sel_d   = win_sel;
          valid_d = 1'b1;
          grant_d = win_oh;
          if (MODE == 1) begin
            ptr_d = win_ptr;
          end
        end
        default: begin
          state_d = S_IDLE;
          sel_d   = '0;
          valid_d = 1'b0;
          grant_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      valid_q    <= 1'b0;
      grant_q    <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
      ptr_q      <= '0;
`ifdef BUS_ARB_CONFLICT_CAPTURE_EN
      mask_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      grant_q    <= grant_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
`ifdef BUS_ARB_CONFLICT_CAPTURE_EN
      mask_q     <= mask_d;
`endif
    end
  end

  assign sel          = sel_q;
  assign sel_valid    = valid_q;
  assign grant        = grant_q;
  assign conflict     = conflict_q;
  assign conflict_cnt = cnt_q;
`ifdef BUS_ARB_CONFLICT_CAPTURE_EN
  assign conflict_mask = mask_q;
`endif

endmodule

// File: doc/bus_source_arbiter.md
Name: bus_source_arbiter

Overview:
Parametrised, registered successor to the combinational bus-source encoder. It takes N_SRC packed drive-request lines, with bit i corresponding to source code i (R0..R15 = 0..15, HI=16, LO=17, ZHI=18, ZLO=19, PC=20, MDR=21, INPORT=22, C=23). It produces a registered bus-mux select code plus a one-hot grant, resolving multi-driver cases by fixed-priority or round-robin policy. It sits between the control unit and the bus multiplexer, and flags and counts illegal multi-driver cycles for debug.

Parameters:
N_SRC, 24, number of bus sources (2..64)
SEL_W, 5, select width; must satisfy 2^SEL_W >= N_SRC
MODE, 0, 0 = fixed priority (lowest index wins), 1 = round robin
CNT_W, 8, width of saturating conflict counter

Ports:
clk  in  1  system clock, rising edge
clr  in  1  reset, synchronous, active-high
en  in  1  advance enable; when 0 all state holds
req  in  N_SRC  source drive requests, bit i = source code i
lock  in  1  hold current grant while its req stays high
sel  out  SEL_W  registered select code to bus mux
sel_valid  out  1  registered; 1 when sel names a granted source
grant  out  N_SRC  registered one-hot grant (all-zero when idle)
conflict  out  1  registered; 1 when the sampled req had more than one bit set
conflict_cnt  out  CNT_W  saturating count of conflict cycles

Behaviour:
- Reset is synchronous, active-high. At a clk edge with clr=1: sel=0, sel_valid=0, grant=0, conflict=0, conflict_cnt=0, round-robin pointer=0, FSM=IDLE. clr has priority over en.
- Latency: exactly 1 cycle. req is sampled at edge k and the result appears after edge k.
- With en=0, all outputs, the pointer and the FSM hold. conflict_cnt does not increment.
- FSM with en=1:
  - IDLE -> GRANT when req != 0.
  - GRANT -> GRANT (hold) when lock=1 and req[sel]=1. sel and grant stay unchanged; other reqs are ignored for grant but still counted for conflict.
  - GRANT -> GRANT (re-arbitrate) when lock=0, or when the held req has dropped and req != 0.
  - GRANT -> IDLE when req == 0.
- Arbitration, MODE=0: winner is the lowest set index. Arbitration is purely a function of the current req.
- Arbitration, MODE=1: search starts at pointer p and proceeds upward, wrapping N_SRC-1 -> 0. The first set bit wins. After granting index k, p = (k+1) mod N_SRC, so granting N_SRC-1 wraps p to 0. The pointer does not change on hold or idle cycles.
- Outputs on grant of index k: sel=k, sel_valid=1, grant=1<<k.
- Outputs in IDLE: sel=0, sel_valid=0, grant=0. This matches the legacy default of code 0 when nothing drives.
- conflict: registered popcount(req)>1, updated every en cycle, including during hold.
- conflict_cnt: increments by 1 on each en cycle where popcount(req)>1. It saturates at 2^CNT_W-1 and never wraps.
- A single req bit always yields that index in either mode, so the block is drop-in equivalent to the old encoder when at most one source drives.
- req bits at index >= N_SRC do not exist. sel values >= N_SRC are never produced.
- clr asserted mid-hold aborts the grant immediately on that edge.

Optional Feature:
BUS_ARB_CONFLICT_CAPTURE_EN
- Defined: adds output conflict_mask [N_SRC]. On the first en cycle with popcount(req)>1 after reset, it latches req. It then holds that value until clr, ignoring later conflicts.
- Not defined: the port and its register are absent. All other behaviour is identical.

Test Plan:
1. clr=1 for 2 edges with req=24'hFFFFFF -> sel=0, sel_valid=0, grant=0, conflict=0, conflict_cnt=0.
2. MODE=0, req=1<<20 (PC) -> one edge later sel=20, grant=24'h100000, sel_valid=1, conflict=0. Then req=0 -> sel=0, sel_valid=0.
3. MODE=0, req=(1<<3)|(1<<21) for 3 edges -> sel=3, conflict=1, conflict_cnt=3. With CAPTURE_EN, conflict_mask=24'h200008.
4. MODE=1, req=(1<<2)|(1<<23) held for 4 edges, lock=0 -> sel sequence 2,23,2,23. The pointer wraps 24 -> 0 after granting 23.
5. lock=1, grant at 5, then req=(1<<5)|(1<<1) for 3 edges -> sel stays 5, conflict_cnt +3. Drop req[5] -> next edge sel=1.
6. CNT_W=2, 5 conflict cycles -> conflict_cnt=3 (saturated). Then en=0 with req changes for 2 edges -> all outputs unchanged.
